// File: rtl/smoldvi_pkg.sv
// Shared definitions for the smoldvi DVI output path: link FSM state
// encodings, the TMDS idle control symbol and small elaboration helpers.
package smoldvi_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RESET     = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_RUN       = 3'd4
  } link_state_e;

  // Control symbol the encoders emit while pattern_sel is high
  localparam logic [9:0] IDLE_CTRL_SYM = 10'b1101010100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/smoldvi_sync_1bit.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0 so a
// lock flag reads as "not locked" until it has been sampled twice.
module smoldvi_sync_1bit (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/smoldvi_link_ctrl.sv
// DVI link start-up/recovery sequencer: waits for stable PLL lock, resets and
// flushes the gearbox, then enables the drivers. SMOLDVI_LINK_CTRL_LOCK_SYNC_EN
// adds a 2-flop synchroniser on pll_locked.
module smoldvi_link_ctrl
  import smoldvi_pkg::*;
#(
  parameter int LOCK_CYCLES  = 1024,
  parameter int RST_CYCLES   = 16,
  parameter int FLUSH_CYCLES = 64,
  parameter int W_ERR        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pll_locked,
  input  logic             clr_err,
  output logic             gearbox_rst_n,
  output logic             pix_rst_n,
  output logic             pattern_sel,
  output logic             out_en,
  output logic             ready,
  output logic [2:0]       state,
  output logic [W_ERR-1:0] lock_loss_count
);

  localparam int CNT_MAX = max3(LOCK_CYCLES, RST_CYCLES, FLUSH_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [W_ERR-1:0] ERR_MAX    = {W_ERR{1'b1}};

  logic lock;

`ifdef SMOLDVI_LINK_CTRL_LOCK_SYNC_EN
  smoldvi_sync_1bit u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (lock)
  );
`else
  assign lock = pll_locked;
`endif

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W_ERR-1:0] err_q, err_d;
  logic             loss_in_run;

  logic gb_rst_n_q, gb_rst_n_d;
  logic pix_rst_n_q, pix_rst_n_d;
  logic pattern_q, pattern_d;
  logic out_en_q, out_en_d;
  logic ready_q, ready_d;

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      err_q       <= '0;
      gb_rst_n_q  <= 1'b0;
      pix_rst_n_q <= 1'b0;
      pattern_q   <= 1'b1;
      out_en_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      gb_rst_n_q  <= gb_rst_n_d;
      pix_rst_n_q <= pix_rst_n_d;
      pattern_q   <= pattern_d;
      out_en_q    <= out_en_d;
      ready_q     <= ready_d;
    end
  end

  // Next state: en=0 wins over everything, then lock loss, then counting
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    loss_in_run = 1'b0;
    if (!en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
        ST_WAIT_LOCK: begin
          if (!lock) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_RESET;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RESET: begin
          if (!lock) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == RST_LAST) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (!lock) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == FLUSH_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock) begin
            state_d     = ST_WAIT_LOCK;
            cnt_d       = '0;
            loss_in_run = 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they move together with state
  always_comb begin
    gb_rst_n_d  = (state_d == ST_FLUSH) || (state_d == ST_RUN);
    pix_rst_n_d = (state_d == ST_FLUSH) || (state_d == ST_RUN);
    pattern_d   = (state_d != ST_RUN);
    out_en_d    = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  // A clear coinciding with a loss still records that loss
  always_comb begin
    err_d = err_q;
    if (clr_err && loss_in_run) begin
      err_d = W_ERR'(1);
    end else if (clr_err) begin
      err_d = '0;
    end else if (loss_in_run && (err_q != ERR_MAX)) begin
      err_d = err_q + W_ERR'(1);
    end
  end

  assign gearbox_rst_n   = gb_rst_n_q;
  assign pix_rst_n       = pix_rst_n_q;
  assign pattern_sel     = pattern_q;
  assign out_en          = out_en_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = err_q;

endmodule
